// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state encoding
// and the operand-width legality rule for the Kogge-Stone based datapaths.
package arith_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } state_t;

   // The adder's prefix tree is built for power-of-two widths up to 16 bits.
   function automatic bit n_is_legal(input int n);
      return (n >= 4) && (n <= 16) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/ksa.sv
// N-bit Kogge-Stone adder: log2(N) prefix levels of (G,P) combining, with the
// carry-in folded into bit 0's generate so every prefix already includes it.
module KSA #(
   parameter int N = 16
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   localparam int LV = $clog2(N);

   logic [N-1:0] w_hp;
   logic [N-1:0] w_g [LV+1];
   logic [N-1:0] w_p [LV];

   assign w_hp   = i_a ^ i_b;
   assign w_g[0] = (i_a & i_b) | {{(N-1){1'b0}}, w_hp[0] & i_cin};
   assign w_p[0] = w_hp;

   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int D = 1 << l;
      for (genvar i = 0; i < N; i++) begin : g_bit
         if (i >= D) begin : g_comb
            assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-D]);
            if (l + 1 < LV) begin : g_p
               assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-D];
            end
         end else begin : g_pass
            // Group spans down to bit 0 already, so it is final.
            assign w_g[l+1][i] = w_g[l][i];
            if (l + 1 < LV) begin : g_p
               assign w_p[l+1][i] = w_p[l][i];
            end
         end
      end
   end

   assign o_sum  = w_hp ^ {w_g[LV][N-2:0], i_cin};
   assign o_cout = w_g[LV][N-1];

endmodule

// File: rtl/seq_mult_ksa.sv
// Sequential unsigned NxN shift-and-add multiplier around one Kogge-Stone adder.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module seq_mult_ksa #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mplr,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   import arith_pkg::*;

   localparam int CW = $clog2(N);

   if (!n_is_legal(N)) begin : g_bad_n
      $error("seq_mult_ksa: N must be a power of two in 4..16");
   end

   state_t         r_state;
   state_t         w_state_nxt;
   logic [2*N-1:0] r_p;
   logic [N-1:0]   r_mc;
   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   w_b;
   logic [N-1:0]   w_sum;
   logic           w_cout;
   logic           w_accept;
   logic           w_last;

   assign in_ready  = (r_state == ST_IDLE) & ~rst;
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state == ST_RUN) | (r_state == ST_DONE);
   assign product   = r_p;

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_cnt == CW'(N - 1));
   assign w_b      = r_p[0] ? r_mc : '0;

   KSA #(.N(N)) u_add (
      .i_a    (r_p[2*N-1:N]),
      .i_b    (w_b),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_p     <= '0;
         r_mc    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_mc  <= mcand;
                  r_p   <= {{N{1'b0}}, mplr};
                  r_cnt <= '0;
               end
            end
            ST_RUN: begin
               // Carry-out lands in the top bit, so no product bit is lost.
               r_p   <= {w_cout, w_sum, r_p[N-1:1]};
               r_cnt <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_ksa.sv
// Self-checking bench for seq_mult_ksa at N=16 and N=8 with an expected-product queue.
module tb_seq_mult_ksa;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] mcand = '0, mplr = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] product;

   logic        in_valid_8 = 1'b0, out_ready_8 = 1'b0;
   logic [7:0]  mcand_8 = '0, mplr_8 = '0;
   logic        in_ready_8, out_valid_8, busy_8;
   logic [15:0] product_8;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_q8[$];

   seq_mult_ksa #(.N(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mcand(mcand), .mplr(mplr), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy)
   );

   seq_mult_ksa #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
      .mcand(mcand_8), .mplr(mplr_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
      .product(product_8), .busy(busy_8)
   );

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input int hold, input bit poke);
      int          lat;
      int          budget;
      logic [31:0] e;
      @(negedge clk);
      budget = 0;
      while (!in_ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL accept16: in_ready=%b required 1", in_ready);
         n_errors++;
         return;
      end
      in_valid = 1'b1; mcand = a; mplr = b;
      exp_q.push_back(32'(a) * 32'(b));
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0; mcand = 16'($urandom); mplr = 16'($urandom);
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || lat != 17) begin
         $display("FAIL latency16: edges=%0d out_valid=%b required 17 and 1", lat, out_valid);
         n_errors++;
         if (out_valid !== 1'b1) return;
      end
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid = 1'b1; mcand = 16'($urandom); mplr = 16'($urandom);
         end
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== e) begin
            $display("FAIL hold16: out_valid=%b in_ready=%b product=%h required 1 0 %h",
                     out_valid, in_ready, product, e);
            n_errors++;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (product !== e) begin
         $display("FAIL product16: a=%h b=%h product=%h required %h", a, b, product, e);
         n_errors++;
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL release16: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                  out_valid, in_ready, busy);
         n_errors++;
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold);
      int          lat;
      logic [15:0] e;
      @(negedge clk);
      n_checks++;
      if (in_ready_8 !== 1'b1) begin
         $display("FAIL accept8: in_ready=%b required 1", in_ready_8);
         n_errors++;
         return;
      end
      in_valid_8 = 1'b1; mcand_8 = a; mplr_8 = b;
      exp_q8.push_back(16'(a) * 16'(b));
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid_8 = 1'b0; mcand_8 = 8'($urandom); mplr_8 = 8'($urandom);
      while (!out_valid_8 && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      e = exp_q8.pop_front();
      n_checks++;
      if (out_valid_8 !== 1'b1 || lat != 9) begin
         $display("FAIL latency8: edges=%0d out_valid=%b required 9 and 1", lat, out_valid_8);
         n_errors++;
         if (out_valid_8 !== 1'b1) return;
      end
      repeat (hold) @(negedge clk);
      out_ready_8 = 1'b1;
      n_checks++;
      if (product_8 !== e || out_valid_8 !== 1'b1) begin
         $display("FAIL product8: a=%h b=%h product=%h valid=%b required %h 1",
                  a, b, product_8, out_valid_8, e);
         n_errors++;
      end
      @(posedge clk);
      @(negedge clk);
      out_ready_8 = 1'b0;
      n_checks++;
      if (out_valid_8 !== 1'b0 || in_ready_8 !== 1'b1) begin
         $display("FAIL release8: out_valid=%b in_ready=%b required 0 1", out_valid_8, in_ready_8);
         n_errors++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 32'h0) begin
         $display("FAIL reset16: in_ready=%b out_valid=%b busy=%b product=%h required 0 0 0 0",
                  in_ready, out_valid, busy, product);
         n_errors++;
      end
      n_checks++;
      if (in_ready_8 !== 1'b0 || out_valid_8 !== 1'b0 || busy_8 !== 1'b0 || product_8 !== 16'h0) begin
         $display("FAIL reset8: in_ready=%b out_valid=%b busy=%b product=%h required 0 0 0 0",
                  in_ready_8, out_valid_8, busy_8, product_8);
         n_errors++;
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || in_ready_8 !== 1'b1) begin
         $display("FAIL reset_release: in_ready=%b in_ready_8=%b required 1 1", in_ready, in_ready_8);
         n_errors++;
      end
   endtask

   task automatic test_basic();
      run16(16'd5, 16'd3, 0, 1'b0);
   endtask

   task automatic test_boundaries();
      run16(16'hFFFF, 16'hFFFF, 0, 1'b0);
      run16(16'h1234, 16'h0000, 0, 1'b0);
      run16(16'h0000, 16'hFFFF, 0, 1'b0);
      run16(16'h8000, 16'h0001, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      run16(16'h00FF, 16'h0101, 5, 1'b1);
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      @(negedge clk);
      in_valid = 1'b1; mcand = 16'hABCD; mplr = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         $display("FAIL midrun_busy: busy=%b required 1", busy);
         n_errors++;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         $display("FAIL midrun_in_ready_rst: in_ready=%b required 0", in_ready);
         n_errors++;
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || product !== 32'h0 || in_ready !== 1'b1) begin
         $display("FAIL midrun_clear: busy=%b out_valid=%b product=%h in_ready=%b required 0 0 0 1",
                  busy, out_valid, product, in_ready);
         n_errors++;
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         $display("FAIL midrun_no_pulse: out_valid seen=1 required 0");
         n_errors++;
      end
      run16(16'd7, 16'd9, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 1000; k++) begin
         run16(16'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
      end
      for (int k = 0; k < 1000; k++) begin
         run8(8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
